// File: rtl/asgn_expr_engine.sv
// Register-file engine executing assignment-expression ops (++/--, =, op=) on NCH channels.
// Multiply is serial shift-add; all other ops complete at the accept edge.
module asgn_expr_engine #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [CW-1:0]    cmd_ch,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  input  logic [CW-1:0]    rd_ch,
  output logic [WIDTH-1:0] rd_data
);

  // Handshake: a transfer happens on a rising edge where valid && ready; a
  // master holds its payload stable while valid is high and ready is low.

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_RESP} state_t;

  localparam logic [3:0] OP_NOP = 4'd0, OP_PRE_INC = 4'd1, OP_POST_INC = 4'd2,
                         OP_PRE_DEC = 4'd3, OP_POST_DEC = 4'd4, OP_ASSIGN = 4'd5,
                         OP_ADD = 4'd6, OP_SUB = 4'd7, OP_MUL = 4'd8, OP_SHL = 4'd9,
                         OP_SHR = 4'd10, OP_ASR = 4'd11;

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0]    CNT_LAST = SW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [CW:0]      NCH_V    = (CW + 1)'(NCH);

  state_t state_q, state_d;

  logic [WIDTH-1:0] ch_q [NCH];
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_next;
  logic [SW-1:0]    cnt_q;
  logic [CW-1:0]    mul_ch_q;

  logic             accept, ch_ok, op_ok, cmd_ok, do_wr, is_mul, ret_old, sh_big;
  logic [SW-1:0]    sh_amt;
  logic [WIDTH-1:0] old_val, new_val, ret_val, asr_raw;

  // Debug-visible FSM state for checkers.
  state_t fsm_state;
  assign fsm_state = state_q;

  always_comb begin
    ch_ok   = ({1'b0, cmd_ch} < NCH_V);
    op_ok   = (cmd_op <= OP_ASR);
    cmd_ok  = ch_ok && op_ok;
    old_val = ch_ok ? ch_q[cmd_ch] : '0;
    sh_big  = (cmd_arg >= WIDTH_V);
    sh_amt  = cmd_arg[SW-1:0];
    asr_raw = $signed(old_val) >>> sh_amt;
    new_val = old_val;
    ret_old = 1'b0;
    do_wr   = 1'b0;
    is_mul  = 1'b0;
    case (cmd_op)
      OP_NOP:      ret_old = 1'b1;
      OP_PRE_INC:  begin new_val = old_val + ONE; do_wr = 1'b1; end
      OP_POST_INC: begin new_val = old_val + ONE; do_wr = 1'b1; ret_old = 1'b1; end
      OP_PRE_DEC:  begin new_val = old_val - ONE; do_wr = 1'b1; end
      OP_POST_DEC: begin new_val = old_val - ONE; do_wr = 1'b1; ret_old = 1'b1; end
      OP_ASSIGN:   begin new_val = cmd_arg; do_wr = 1'b1; end
      OP_ADD:      begin new_val = old_val + cmd_arg; do_wr = 1'b1; end
      OP_SUB:      begin new_val = old_val - cmd_arg; do_wr = 1'b1; end
      OP_MUL:      is_mul = 1'b1;
      OP_SHL:      begin new_val = sh_big ? '0 : (old_val << sh_amt); do_wr = 1'b1; end
      OP_SHR:      begin new_val = sh_big ? '0 : (old_val >> sh_amt); do_wr = 1'b1; end
      OP_ASR:      begin new_val = sh_big ? {WIDTH{old_val[WIDTH-1]}} : asr_raw; do_wr = 1'b1; end
      default:     ;
    endcase
    ret_val  = ret_old ? old_val : new_val;
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    accept    = cmd_valid && cmd_ready;
    case (state_q)
      S_IDLE: if (accept) state_d = (cmd_ok && is_mul) ? S_MUL : S_RESP;
      S_MUL:  if (cnt_q == CNT_LAST) state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) ch_q[i] <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      mul_ch_q   <= '0;
    end else begin
      if (accept) begin
        rsp_err_q  <= !cmd_ok;
        rsp_data_q <= cmd_ok ? ret_val : '0;
        if (cmd_ok && do_wr) ch_q[cmd_ch] <= new_val;
        if (cmd_ok && is_mul) begin
          mcand_q  <= old_val;
          mplier_q <= cmd_arg;
          acc_q    <= '0;
          cnt_q    <= '0;
          mul_ch_q <= cmd_ch;
        end
      end
      // One multiplier bit per cycle; the channel keeps its old value until the last step.
      if (state_q == S_MUL) begin
        acc_q    <= acc_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + SW'(1);
        if (cnt_q == CNT_LAST) begin
          ch_q[mul_ch_q] <= acc_next;
          rsp_data_q     <= acc_next;
        end
      end
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign rd_data  = ({1'b0, rd_ch} < NCH_V) ? ch_q[rd_ch] : '0;

endmodule

// File: tb/tb_asgn_expr_engine.sv
// Bench for asgn_expr_engine: a 32-bit/4-channel instance (3-bit channel index so
// out-of-range channels are reachable) and an 8-bit/2-channel instance for wrap cases.
module tb_asgn_expr_engine;

  localparam logic [3:0] NOP = 4'd0, PRE_INC = 4'd1, POST_INC = 4'd2, PRE_DEC = 4'd3,
                         POST_DEC = 4'd4, ASSIGN = 4'd5, ADD = 4'd6, SUB = 4'd7,
                         MUL = 4'd8, SHL = 4'd9, SHR = 4'd10, ASR = 4'd11;

  logic        clk = 1'b0;
  logic        rst_n, sel8, cmd_valid, rsp_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_ch, rd_ch;
  logic [31:0] cmd_arg;

  logic        rdy32, rv32, re32;
  logic [31:0] rdat32, rdd32;
  logic        rdy8, rv8, re8;
  logic [7:0]  rdat8, rdd8;

  logic        cmd_ready_m, rsp_valid_m, rsp_err_m;
  logic [31:0] rsp_data_m, rd_data_m;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_e;
  logic [31:0] m32 [4];

  always #5 clk = ~clk;

  asgn_expr_engine #(.WIDTH(32), .NCH(4), .CW(3)) dut32 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid && !sel8), .cmd_ready(rdy32),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_arg(cmd_arg),
    .rsp_valid(rv32), .rsp_ready(rsp_ready), .rsp_data(rdat32), .rsp_err(re32),
    .rd_ch(rd_ch), .rd_data(rdd32)
  );

  asgn_expr_engine #(.WIDTH(8), .NCH(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid && sel8), .cmd_ready(rdy8),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch[0]), .cmd_arg(cmd_arg[7:0]),
    .rsp_valid(rv8), .rsp_ready(rsp_ready), .rsp_data(rdat8), .rsp_err(re8),
    .rd_ch(rd_ch[0]), .rd_data(rdd8)
  );

  assign cmd_ready_m = sel8 ? rdy8 : rdy32;
  assign rsp_valid_m = sel8 ? rv8 : rv32;
  assign rsp_err_m   = sel8 ? re8 : re32;
  assign rsp_data_m  = sel8 ? {24'b0, rdat8} : rdat32;
  assign rd_data_m   = sel8 ? {24'b0, rdd8} : rdd32;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for the 32-bit instance.
  function automatic void model(input logic [3:0] op, input logic [31:0] old,
                                input logic [31:0] arg, output logic [31:0] nv,
                                output logic [31:0] rv);
    nv = old;
    rv = old;
    case (op)
      PRE_INC:  begin nv = old + 32'd1; rv = nv; end
      POST_INC: begin nv = old + 32'd1; rv = old; end
      PRE_DEC:  begin nv = old - 32'd1; rv = nv; end
      POST_DEC: begin nv = old - 32'd1; rv = old; end
      ASSIGN:   begin nv = arg; rv = nv; end
      ADD:      begin nv = old + arg; rv = nv; end
      SUB:      begin nv = old - arg; rv = nv; end
      MUL:      begin nv = old * arg; rv = nv; end
      SHL:      begin nv = (arg >= 32) ? 32'd0 : old << arg[4:0]; rv = nv; end
      SHR:      begin nv = (arg >= 32) ? 32'd0 : old >> arg[4:0]; rv = nv; end
      ASR:      begin
                  nv = (arg >= 32) ? {32{old[31]}} : 32'($signed(old) >>> arg[4:0]);
                  rv = nv;
                end
      default:  ;
    endcase
  endfunction

  // Scoreboard: pop one expectation per completed response handshake.
  always @(negedge clk) begin
    if (rst_n && rsp_valid_m && rsp_ready) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        exp_e = exp_q.pop_front();
        check("rsp", {31'b0, rsp_err_m, rsp_data_m}, {31'b0, exp_e});
      end
    end
  end

  task automatic do_cmd(input logic [3:0] op, input logic [2:0] ch, input logic [31:0] arg,
                        input logic [31:0] exp, input logic exp_err, input int exp_lat);
    int n;
    bit ok;
    bit rdy_seen;
    exp_q.push_back({exp_err, exp});
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_ch = ch; cmd_arg = arg;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready_m) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
      void'(exp_q.pop_back());
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0; ok = 1'b0; rdy_seen = 1'b0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (rsp_valid_m) begin ok = 1'b1; break; end
      if (cmd_ready_m) rdy_seen = 1'b1;
    end
    if (!ok) check("rsp_timeout", 0, 1);
    else check("latency", n, exp_lat);
    check("busy_ready", rdy_seen, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] nv, rv, arg;
    logic [3:0]  op;
    logic [2:0]  ch;
    bit          seen;

    rst_n = 1'b0; sel8 = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_op = NOP; cmd_ch = '0; cmd_arg = '0; rd_ch = '0;
    #1;
    check("rst_cmd_ready", cmd_ready_m, 1);
    check("rst_rsp_valid", rsp_valid_m, 0);
    check("rst_rsp_data", rsp_data_m, 0);
    check("rst_rsp_err", rsp_err_m, 0);
    check("rst_rd_ch0", rd_data_m, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Pre/post semantics on ch0.
    do_cmd(ASSIGN, 0, 32'd0, 32'd0, 0, 1);
    do_cmd(POST_INC, 0, 32'd0, 32'd0, 0, 1);
    do_cmd(PRE_INC, 0, 32'd0, 32'd2, 0, 1);
    do_cmd(PRE_DEC, 0, 32'd0, 32'd1, 0, 1);
    rd_ch = 3'd0; #1 check("rd_ch0", rd_data_m, 1);

    // Chained compounds on ch1, serial multiply latency.
    do_cmd(ASSIGN, 1, 32'd99, 32'd99, 0, 1);
    do_cmd(ADD, 1, 32'd1, 32'd100, 0, 1);
    do_cmd(MUL, 1, 32'd2, 32'd200, 0, 33);
    do_cmd(SHR, 1, 32'd2, 32'd50, 0, 1);
    do_cmd(SHR, 1, 32'hFFFF_FFFF, 32'd0, 0, 1);

    // Signed-ish wrap cases on ch2.
    do_cmd(ASSIGN, 2, 32'd5, 32'd5, 0, 1);
    do_cmd(SUB, 2, 32'd7, 32'hFFFF_FFFE, 0, 1);
    do_cmd(SHL, 2, 32'd4, 32'hFFFF_FFE0, 0, 1);
    do_cmd(ASR, 2, 32'd4, 32'hFFFF_FFFE, 0, 1);
    do_cmd(MUL, 2, 32'hFFFF_FFFF, 32'd2, 0, 33);
    do_cmd(POST_DEC, 2, 32'd0, 32'd2, 0, 1);
    do_cmd(NOP, 2, 32'd123, 32'd1, 0, 1);
    rd_ch = 3'd2; #1 check("rd_ch2", rd_data_m, 1);

    // Synchronise the model, then random ops checked against it.
    for (int i = 0; i < 4; i++) begin
      m32[i] = $urandom;
      do_cmd(ASSIGN, 3'(i), m32[i], m32[i], 0, 1);
    end
    for (int i = 0; i < 24; i++) begin
      op  = 4'($urandom_range(0, 11));
      ch  = 3'($urandom_range(0, 3));
      arg = (op >= SHL) ? 32'($urandom_range(0, 40)) : $urandom;
      model(op, m32[ch[1:0]], arg, nv, rv);
      do_cmd(op, ch, arg, rv, 0, (op == MUL) ? 33 : 1);
      m32[ch[1:0]] = nv;
    end

    // Illegal op and out-of-range channels leave every channel untouched.
    do_cmd(4'd13, 0, 32'd1, 32'd0, 1, 1);
    do_cmd(ADD, 5, 32'd1, 32'd0, 1, 1);
    do_cmd(MUL, 7, 32'd3, 32'd0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      rd_ch = 3'(i); #1 check("err_unchanged", rd_data_m, m32[i]);
    end
    rd_ch = 3'd5; #1 check("rd_out_of_range", rd_data_m, 0);

    // Backpressure: response must hold and a pending command must wait.
    rsp_ready = 1'b0;
    do_cmd(PRE_INC, 3, 32'd0, m32[3] + 32'd1, 0, 1);
    m32[3] = m32[3] + 32'd1;
    cmd_valid = 1'b1; cmd_op = ASSIGN; cmd_ch = 3'd3; cmd_arg = 32'd77;
    exp_q.push_back({1'b0, 32'd77});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid_m, 1);
      check("bp_rsp_data", rsp_data_m, m32[3]);
      check("bp_cmd_ready", cmd_ready_m, 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_still_busy", cmd_ready_m, 0);
    @(negedge clk);
    check("bp_ready_after", cmd_ready_m, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("bp_second_rsp", rsp_valid_m, 1);
    @(posedge clk);
    #1;

    // 8-bit wrap and shift boundaries.
    sel8 = 1'b1;
    do_cmd(ASSIGN, 0, 32'hFF, 32'hFF, 0, 1);
    do_cmd(PRE_INC, 0, 32'd0, 32'h00, 0, 1);
    do_cmd(ASSIGN, 1, 32'd0, 32'h00, 0, 1);
    do_cmd(POST_DEC, 1, 32'd0, 32'h00, 0, 1);
    rd_ch = 3'd1; #1 check("w8_rd_ch1", rd_data_m, 32'hFF);
    do_cmd(ASR, 1, 32'd1, 32'hFF, 0, 1);
    do_cmd(ASSIGN, 1, 32'h80, 32'h80, 0, 1);
    do_cmd(ASR, 1, 32'd200, 32'hFF, 0, 1);
    do_cmd(SHL, 1, 32'd8, 32'h00, 0, 1);
    do_cmd(PRE_DEC, 0, 32'd0, 32'hFF, 0, 1);
    do_cmd(SHR, 0, 32'hFF, 32'h00, 0, 1);
    do_cmd(ASSIGN, 0, 32'h13, 32'h13, 0, 1);
    do_cmd(MUL, 0, 32'h11, 32'h43, 0, 9);
    sel8 = 1'b0;

    // Reset mid-multiply aborts without write or response.
    do_cmd(ASSIGN, 2, 32'd7, 32'd7, 0, 1);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = MUL; cmd_ch = 3'd2; cmd_arg = 32'd3;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    rd_ch = 3'd2;
    #1;
    check("mrst_cmd_ready", cmd_ready_m, 1);
    check("mrst_rsp_valid", rsp_valid_m, 0);
    check("mrst_rsp_data", rsp_data_m, 0);
    check("mrst_rsp_err", rsp_err_m, 0);
    check("mrst_rd_ch2", rd_data_m, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid_m) seen = 1'b1;
    end
    check("mrst_no_rsp", seen, 0);
    check("mrst_rd_ch2_after", rd_data_m, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/asgn_expr_engine.md
Name: asgn_expr_engine

Overview:
- Parametrised register-file engine that executes SystemVerilog-style assignment-expression operations (pre/post increment and decrement, plain assign, compound `+=`, `-=`, `*=`, `<<=`, `>>=`, `>>>=`) on NCH independent WIDTH-bit channels.
- Each operation returns the value of the expression, with pre/post semantics.
- Multiplication is serial (shift-add), so the block has a real busy/response FSM.
- Used as a synthesis/formal regression block for expression-with-side-effect lowering, and as a generic accumulator bank.

Parameters:
- WIDTH, 32, data width of every channel, operand and result (min 2).
- NCH, 4, number of channels (min 1).
- CW, $clog2(NCH) (1 when NCH==1), channel index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_op  in  4  opcode: 0 NOP, 1 PRE_INC, 2 POST_INC, 3 PRE_DEC, 4 POST_DEC, 5 ASSIGN, 6 ADD, 7 SUB, 8 MUL, 9 SHL, 10 SHR (logical), 11 ASR (arithmetic); 12-15 reserved.
- cmd_ch  in  CW  target channel.
- cmd_arg  in  WIDTH  operand; for shifts it is an unsigned shift amount.
- rsp_valid  out  1  expression result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  WIDTH  expression value.
- rsp_err  out  1  response belongs to an illegal op or an out-of-range channel.
- rd_ch  in  CW  debug read select.
- rd_data  out  WIDTH  combinational current value of channel rd_ch; 0 if rd_ch >= NCH.

Behaviour:
- Reset (async, rst_n low):
  - All channels clear to 0.
  - FSM goes to IDLE.
  - Outputs: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0.
  - Reset asserted mid-operation aborts it: no channel write, no response.
- FSM states: IDLE, MUL, RESP. cmd_ready is 1 only in IDLE.
- Accept: cmd_valid && cmd_ready at a rising edge.
- Non-MUL ops:
  - The channel is written at the accept edge.
  - The FSM moves to RESP; rsp_valid=1 in the following cycle, i.e. latency 1.
- MUL:
  - Operands are latched at accept; the FSM moves to MUL.
  - One multiplier bit is processed per cycle for exactly WIDTH cycles.
  - On the last cycle the channel is written and the FSM moves to RESP.
  - rsp_valid rises WIDTH+1 cycles after accept.
  - The product is the low WIDTH bits; it is identical for signed and unsigned interpretation.
- RESP:
  - rsp_valid, rsp_data and rsp_err hold stable until rsp_valid && rsp_ready.
  - Then the FSM returns to IDLE; cmd_ready=1 in the next cycle.
  - Back-to-back throughput is therefore 1 op per 2 cycles minimum.
- Result values (old = channel before the op, new = after):
  - PRE_INC / PRE_DEC return new.
  - POST_INC / POST_DEC return old.
  - ASSIGN and all compound ops return new.
  - NOP returns old and writes nothing.
- Arithmetic: all wraps modulo 2^WIDTH, no saturation.
  - Max value PRE_INC returns 0.
  - 0 PRE_DEC returns all-ones.
- Shifts: amount is cmd_arg treated as unsigned, full width.
  - Amount >= WIDTH gives 0 for SHL and SHR.
  - Amount >= WIDTH gives sign replication for ASR.
  - An all-ones cmd_arg is a huge amount, never -1.
- Errors: reserved opcode or cmd_ch >= NCH:
  - No channel write.
  - Goes to RESP with rsp_err=1, rsp_data=0.
- rd_data:
  - Reflects register state; an update at edge t is visible after t.
  - During MUL it shows the old value.
- A command presented while cmd_ready=0 is ignored; the master must hold it.

Test Plan:
- Reset, then ASSIGN ch0=0, POST_INC ch0, PRE_INC ch0, PRE_DEC ch0 -> rsp_data 0, 0, 2, 1; rd_data(ch0)=1; each rsp_valid exactly 1 cycle after accept.
- Chained compounds on ch1: ASSIGN 99, ADD 1, MUL 2, SHR 2, SHR 32'hFFFF_FFFF -> responses 99, 100, 200, 50, 0.
  - MUL rsp_valid exactly 33 cycles after accept, with cmd_ready=0 throughout.
- Wrap test with WIDTH=8, NCH=2:
  - ch0=8'hFF, PRE_INC -> 0.
  - ch1=0, POST_DEC -> 0, then rd_data=8'hFF.
  - ch1 ASR 1 -> 8'hFF.
  - ASSIGN 8'h80 then ASR 200 -> 8'hFF; SHL 8 -> 0.
- Backpressure: hold rsp_ready=0 for 5 cycles after a PRE_INC -> rsp_valid/rsp_data stable, cmd_ready=0, a second cmd_valid is not accepted; accepted 1 cycle after rsp_ready.
- Errors: op 13 and cmd_ch=5 with NCH=4 -> rsp_err=1, rsp_data=0, all channels unchanged.
- Reset mid-MUL: pull rst_n low 10 cycles into a MUL on ch2=7, arg 3 -> outputs immediately at reset values, ch2=0, no rsp_valid after release.
